shifter_operand_sequencer: RTL
==============================

// Module: shifter_operand_sequencer
// PURPOSE
//  Multi-cycle controller that turns the 12-bit shifter_operand field of an ARM data-processing
//  instruction (I bit 25) into barrel_shifter control. It reads Rm/Rs from the register file,
//  converts the special encodings (LSR/ASR #0 = 32, ROR #0 = RRX, immediate rotate = 2*rot),
//  drives the shared barrel_shifter and returns operand + shifter carry-out to execute.
// PARAMETERS
//  RF_ADDR_W      4        register-file address width
//  ILLEGAL_VALUE  32'h0    out_operand value for a non-shifter encoding (bit4=1 and bit7=1)
// PORTS
//  clk            in   1   clock, all state changes on rising edge
//  rst_n          in   1   asynchronous reset, active-low
//  in_valid       in   1   instruction offered
//  in_ready       out  1   block can accept (combinational from state)
//  in_instr       in   32  instruction word; bits 25 and 11:0 used
//  in_carry       in   1   current CPSR C flag
//  rf_rd_en       out  1   register read request; data returned the following cycle
//  rf_addr        out  RF_ADDR_W  register to read (Rm = instr[3:0], Rs = instr[11:8])
//  rf_rd_data     in   32  read data, valid the cycle after rf_rd_en
//  bs_data        out  32  barrel_shifter in_data
//  bs_shift_value out  8   barrel_shifter shift_value
//  bs_op_select   out  3   LSL 000, LSR 001, ASR 010, ROR 011, RRX 100
//  bs_carry_in    out  1   barrel_shifter in_carry (latched in_carry)
//  bs_result      in   32  barrel_shifter out_shifted_data
//  bs_carry_out   in   1   barrel_shifter out_carry
//  out_valid      out  1   result valid; held until out_ready
//  out_ready      in   1   consumer accepts result
//  out_operand    out  32  shifter_operand value
//  out_carry      out  1   shifter_carry_out
//  out_illegal    out  1   encoding was not a shifter operand
// BEHAVIOUR
//  - Reset: state IDLE; out_valid, out_operand, out_carry, out_illegal, rf_rd_en, rf_addr,
//    all bs_* = 0; in_ready = 1. Reset mid-operation aborts; transaction discarded, no out_valid.
//  - Accept on in_valid & in_ready: latch in_instr, in_carry. bs_* driven from internal regs only.
//  - Decode: I=1 -> imm: bs_data={24'b0,imm8}, op ROR, shift={3'b0,rot,1'b0} (rot=0 -> carry=C).
//    I=0,bit4=0 -> imm shift: type=instr[6:5], amt=instr[11:7]; LSL #0 -> shift 0;
//    LSR/ASR #0 -> shift 32; ROR #0 -> op RRX, shift 1; else shift={3'b0,amt}.
//    I=0,bit4=1,bit7=0 -> reg shift: op=type, shift=Rs[7:0] (0 passes Rm, carry=C).
//    I=0,bit4=1,bit7=1 -> illegal: no reads, out_operand=ILLEGAL_VALUE, out_carry=C, out_illegal=1.
//  - FSM: IDLE -> EXEC (imm), RD_RM (shift forms), DONE (illegal).
//    RD_RM: rf_rd_en=1, rf_addr=Rm -> RD_RS if reg shift else LAST_RD.
//    RD_RS: rf_rd_en=1, rf_addr=Rs; capture rf_rd_data as Rm at end -> LAST_RD.
//    LAST_RD: capture rf_rd_data as Rm (imm shift) or Rs[7:0] (reg shift) -> EXEC.
//    EXEC: bs_* valid; capture bs_result/bs_carry_out into out_* at end -> DONE.
//    DONE: out_valid=1, out_* stable; out_ready -> IDLE (out_valid drops next cycle).
//  - Latency (accept edge to out_valid high): imm 2, imm shift 4, reg shift 5, illegal 1 cycles.
//  - rf_rd_en never asserted in IDLE/LAST_RD/EXEC/DONE; in_ready=0 outside IDLE.
// CONFIGURATION
//  SHOPSEQ_BACK2BACK_EN defined: in_ready also high in DONE when out_ready=1; a same-cycle
//    accept moves DONE directly to the new instruction's first state (no IDLE bubble).
//  Not defined: in_ready high only in IDLE; one idle cycle between transactions.
// TESTING
//  1 I=1 rot=1 imm8=FF C=0 -> out_operand C000003F, carry 1, valid +2, no rf_rd_en.
//  2 LSR #0, Rm=80000001 -> bs op 001 shift 32; operand 00000000, carry 1, valid +4.
//  3 ROR #0, Rm=00000003, C=1 -> bs op 100 shift 1; operand 80000001, carry 1.
//  4 LSL by Rs=00000121, Rm=FFFFFFFF -> rf_addr Rm then Rs on consecutive cycles;
//    shift 8'h21; operand 0, carry 0, valid +5.
//  5 out_ready low 3 cycles in DONE -> out_* stable, in_ready 0 (1 if BACK2BACK_EN and
//    out_ready); bit4=1 bit7=1 -> out_illegal 1, ILLEGAL_VALUE, valid +1, no reads.
//  6 rst_n low during RD_RS -> rf_rd_en 0 immediately, no out_valid; next imm accept correct.

Source files
------------

// File: rtl/shifter_operand_sequencer_if.sv
// Handshake/bus bundle for shifter_operand_sequencer: instruction intake, register-file
// read port, shared barrel_shifter port and result output.
interface shifter_operand_sequencer_if #(
  parameter int RF_ADDR_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic                 in_carry;
  logic                 rf_rd_en;
  logic [RF_ADDR_W-1:0] rf_addr;
  logic [31:0]          rf_rd_data;
  logic [31:0]          bs_data;
  logic [7:0]           bs_shift_value;
  logic [2:0]           bs_op_select;
  logic                 bs_carry_in;
  logic [31:0]          bs_result;
  logic                 bs_carry_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_operand;
  logic                 out_carry;
  logic                 out_illegal;

  modport slave (
    input  in_valid, in_instr, in_carry, rf_rd_data, bs_result, bs_carry_out, out_ready,
    output in_ready, rf_rd_en, rf_addr, bs_data, bs_shift_value, bs_op_select, bs_carry_in,
           out_valid, out_operand, out_carry, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_carry, rf_rd_data, bs_result, bs_carry_out, out_ready,
    input  in_ready, rf_rd_en, rf_addr, bs_data, bs_shift_value, bs_op_select, bs_carry_in,
           out_valid, out_operand, out_carry, out_illegal
  );
endinterface

// File: rtl/shifter_operand_sequencer.sv
// Sequences ARM data-processing shifter_operand decode: RF reads, barrel_shifter drive, result.
// Optional macro SHOPSEQ_BACK2BACK_EN: accept a new instruction straight out of DONE.
module shifter_operand_sequencer #(
  parameter int          RF_ADDR_W     = 4,
  parameter logic [31:0] ILLEGAL_VALUE = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  shifter_operand_sequencer_if.slave   io_bus
);

  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_RRX = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_RM, S_RD_RS, S_LAST_RD, S_EXEC, S_DONE
  } state_t;

  state_t               r_state;
  logic                 r_regsh;
  logic                 r_c;
  logic [2:0]           r_op;
  logic [7:0]           r_shift;
  logic [RF_ADDR_W-1:0] r_rs_addr;
  logic [31:0]          r_rm;

  logic                 r_rf_rd_en;
  logic [RF_ADDR_W-1:0] r_rf_addr;
  logic [31:0]          r_bs_data;
  logic [7:0]           r_bs_shift;
  logic [2:0]           r_bs_op;
  logic                 r_bs_carry;
  logic                 r_out_valid;
  logic [31:0]          r_out_operand;
  logic                 r_out_carry;
  logic                 r_out_illegal;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_illegal;
  logic        w_regsh;
  logic [2:0]  w_op;
  logic [7:0]  w_shift;
  logic [31:0] w_instr;
  logic        w_unused_bits;

  assign w_instr       = io_bus.in_instr;
  assign w_unused_bits = ^{w_instr[31:26], w_instr[24:12]};
  assign w_illegal     = !w_instr[25] && w_instr[4] && w_instr[7];
  assign w_regsh       = !w_instr[25] && w_instr[4] && !w_instr[7];

  // Special #0 encodings are folded into op/shift here so EXEC sees plain shifter controls.
  always_comb begin
    w_op    = {1'b0, w_instr[6:5]};
    w_shift = {3'b0, w_instr[11:7]};
    if (w_instr[25]) begin
      w_op    = OP_ROR;
      w_shift = {3'b0, w_instr[11:8], 1'b0};
    end else if (!w_instr[4] && (w_instr[11:7] == 5'd0)) begin
      case (w_instr[6:5])
        2'b00:   w_shift = 8'd0;
        2'b11: begin
          w_op    = OP_RRX;
          w_shift = 8'd1;
        end
        default: w_shift = 8'd32;
      endcase
    end
  end

`ifdef SHOPSEQ_BACK2BACK_EN
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && io_bus.out_ready);
`else
  assign w_in_ready = (r_state == S_IDLE);
`endif
  assign w_accept = io_bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_regsh       <= 1'b0;
      r_c           <= 1'b0;
      r_op          <= 3'b0;
      r_shift       <= 8'b0;
      r_rs_addr     <= '0;
      r_rm          <= 32'b0;
      r_rf_rd_en    <= 1'b0;
      r_rf_addr     <= '0;
      r_bs_data     <= 32'b0;
      r_bs_shift    <= 8'b0;
      r_bs_op       <= 3'b0;
      r_bs_carry    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_operand <= 32'b0;
      r_out_carry   <= 1'b0;
      r_out_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_RD_RM: begin
          if (r_regsh) begin
            r_rf_addr <= r_rs_addr;
            r_state   <= S_RD_RS;
          end else begin
            r_rf_rd_en <= 1'b0;
            r_state    <= S_LAST_RD;
          end
        end
        S_RD_RS: begin
          r_rf_rd_en <= 1'b0;
          r_rm       <= io_bus.rf_rd_data;
          r_state    <= S_LAST_RD;
        end
        S_LAST_RD: begin
          r_bs_op <= r_op;
          if (r_regsh) begin
            r_bs_data  <= r_rm;
            r_bs_shift <= io_bus.rf_rd_data[7:0];
          end else begin
            r_bs_data  <= io_bus.rf_rd_data;
            r_bs_shift <= r_shift;
          end
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          // A zero shift passes the operand through with the current C flag.
          if ((r_bs_shift == 8'd0) && (r_bs_op != OP_RRX)) begin
            r_out_operand <= r_bs_data;
            r_out_carry   <= r_c;
          end else begin
            r_out_operand <= io_bus.bs_result;
            r_out_carry   <= io_bus.bs_carry_out;
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Accept overrides the DONE exit above when back-to-back issue is enabled.
      if (w_accept) begin
        r_c           <= io_bus.in_carry;
        r_bs_carry    <= io_bus.in_carry;
        r_op          <= w_op;
        r_shift       <= w_shift;
        r_regsh       <= w_regsh;
        r_rs_addr     <= RF_ADDR_W'(w_instr[11:8]);
        r_out_illegal <= w_illegal;
        if (w_instr[25]) begin
          r_bs_data  <= {24'b0, w_instr[7:0]};
          r_bs_op    <= w_op;
          r_bs_shift <= w_shift;
          r_state    <= S_EXEC;
        end else if (w_illegal) begin
          r_out_operand <= ILLEGAL_VALUE;
          r_out_carry   <= io_bus.in_carry;
          r_out_valid   <= 1'b1;
          r_state       <= S_DONE;
        end else begin
          r_rf_rd_en <= 1'b1;
          r_rf_addr  <= RF_ADDR_W'(w_instr[3:0]);
          r_state    <= S_RD_RM;
        end
      end
    end
  end

  assign io_bus.in_ready       = w_in_ready;
  assign io_bus.rf_rd_en       = r_rf_rd_en;
  assign io_bus.rf_addr        = r_rf_addr;
  assign io_bus.bs_data        = r_bs_data;
  assign io_bus.bs_shift_value = r_bs_shift;
  assign io_bus.bs_op_select   = r_bs_op;
  assign io_bus.bs_carry_in    = r_bs_carry;
  assign io_bus.out_valid      = r_out_valid;
  assign io_bus.out_operand    = r_out_operand;
  assign io_bus.out_carry      = r_out_carry;
  assign io_bus.out_illegal    = r_out_illegal;

endmodule
